// File: rtl/paint_pkg.sv
// Shared types and widths for the circle painter scheduling path.
package paint_pkg;

   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;
   localparam int RADIUS_W = 17;

   // Cycles the painter may keep ready high after a pulse before we assume it took the circle.
   localparam int ACCEPT_TIMEOUT = 4;

   typedef struct packed {
      logic [HCOUNT_W-1:0] hcount;
      logic [VCOUNT_W-1:0] vcount;
      logic [RADIUS_W-1:0] radius;
   } circle_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_ACCEPT,
      ST_WAIT_DONE
   } sched_state_t;

   function automatic logic [RADIUS_W-1:0] clamp_radius(input logic [RADIUS_W-1:0] r,
                                                        input int max_r);
      return (r > RADIUS_W'(max_r)) ? RADIUS_W'(max_r) : r;
   endfunction

endpackage

// File: rtl/circle_fifo.sv
// Small circular FIFO of circles; the head is readable combinationally so a pop
// and the load of its contents happen on the same edge.
module circle_fifo
   import paint_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     push,
   input  logic                     pop,
   input  circle_t                  wr_data,
   output circle_t                  rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   circle_t              mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [PTR_W:0]       count_reg;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rd_data = mem[rd_ptr_reg];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is not reset: emptiness is tracked entirely by the pointers and count.
   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (!do_push && do_pop) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/paint_scheduler.sv
// Round-robin arbitration of circle requests into a FIFO, and an issue FSM that
// hands one circle at a time to the painter using its ready handshake.
module paint_scheduler
   import paint_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_RADIUS = 64
) (
   input  logic                               clk_in,
   input  logic                               rst_n_in,
   input  logic [NUM_REQ-1:0]                 req_valid_in,
   input  logic [NUM_REQ-1:0][HCOUNT_W-1:0]   req_hcount_in,
   input  logic [NUM_REQ-1:0][VCOUNT_W-1:0]   req_vcount_in,
   input  logic [NUM_REQ-1:0][RADIUS_W-1:0]   req_radius_in,
   output logic [NUM_REQ-1:0]                 req_ready_out,
   input  logic                               painter_ready_in,
   output logic                               painter_valid_out,
   output logic [HCOUNT_W-1:0]                painter_hcount_out,
   output logic [VCOUNT_W-1:0]                painter_vcount_out,
   output logic [RADIUS_W-1:0]                painter_radius_out,
   output logic                               busy_out,
   output logic [15:0]                        issued_count_out,
   output logic [15:0]                        drop_count_out
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]             rr_ptr_reg;
   logic [PTR_W-1:0]             rr_ptr_next;
   logic [NUM_REQ-1:0]           grant_onehot;
   logic [PTR_W-1:0]             grant_idx;
   logic                         grant_found;
   logic [PTR_W-1:0]             search_idx;
   int                           search_sum;
   logic                         accept;
   circle_t                      push_circle;
   logic                         fifo_push;
   logic                         fifo_pop;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   circle_t                      fifo_head;
   logic [15:0]                  drop_count_reg;

   sched_state_t                 state_reg;
   logic [1:0]                   wait_cnt_reg;
   logic                         painter_valid_reg;
   circle_t                      painter_circle_reg;
   logic [15:0]                  issued_count_reg;

   // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_found  = 1'b0;
      search_sum   = 0;
      search_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         search_sum = int'(rr_ptr_reg) + i;
         if (search_sum >= NUM_REQ) search_sum = search_sum - NUM_REQ;
         search_idx = PTR_W'(search_sum);
         if (!grant_found && req_valid_in[search_idx]) begin
            grant_found              = 1'b1;
            grant_idx                = search_idx;
            grant_onehot[search_idx] = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready_out[gi] = grant_onehot[gi] & ~fifo_full;
      end
   endgenerate

   assign accept      = grant_found && !fifo_full;
   assign rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   assign push_circle.hcount = req_hcount_in[grant_idx];
   assign push_circle.vcount = req_vcount_in[grant_idx];
   assign push_circle.radius = clamp_radius(req_radius_in[grant_idx], MAX_RADIUS);

   // Zero-radius circles are consumed (and counted) but never reach the painter.
   assign fifo_push = accept && (req_radius_in[grant_idx] != '0);
   assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty && painter_ready_in;

   circle_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .wr_data  (push_circle),
      .rd_data  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rr_ptr_reg     <= '0;
         drop_count_reg <= '0;
      end else if (accept) begin
         rr_ptr_reg <= rr_ptr_next;
         if (req_radius_in[grant_idx] == '0) drop_count_reg <= drop_count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg          <= ST_IDLE;
         wait_cnt_reg       <= '0;
         painter_valid_reg  <= 1'b0;
         painter_circle_reg <= '0;
         issued_count_reg   <= '0;
      end else begin
         painter_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (fifo_pop) begin
                  painter_valid_reg  <= 1'b1;
                  painter_circle_reg <= fifo_head;
                  issued_count_reg   <= issued_count_reg + 16'd1;
                  wait_cnt_reg       <= '0;
                  state_reg          <= ST_WAIT_ACCEPT;
               end
            end
            ST_WAIT_ACCEPT: begin
               // A painter that never drops ready is assumed to have taken the circle.
               if (!painter_ready_in) begin
                  state_reg <= ST_WAIT_DONE;
               end else if (wait_cnt_reg == 2'(ACCEPT_TIMEOUT - 1)) begin
                  state_reg <= ST_IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 2'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (painter_ready_in) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign painter_valid_out  = painter_valid_reg;
   assign painter_hcount_out = painter_circle_reg.hcount;
   assign painter_vcount_out = painter_circle_reg.vcount;
   assign painter_radius_out = painter_circle_reg.radius;
   assign issued_count_out   = issued_count_reg;
   assign drop_count_out     = drop_count_reg;
   assign busy_out           = (fifo_count != '0) || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler: arbitration order, radius rules, FIFO full
// behaviour, painter handshake timing and asynchronous reset.
module tb_paint_scheduler;

   logic              clk_in = 1'b0;
   logic              rst_n_in = 1'b0;
   logic [3:0]        req_valid_in = '0;
   logic [3:0][10:0]  req_hcount_in = '0;
   logic [3:0][9:0]   req_vcount_in = '0;
   logic [3:0][16:0]  req_radius_in = '0;
   logic [3:0]        req_ready_out;
   logic              painter_ready_in;
   logic              painter_valid_out;
   logic [10:0]       painter_hcount_out;
   logic [9:0]        painter_vcount_out;
   logic [16:0]       painter_radius_out;
   logic              busy_out;
   logic [15:0]       issued_count_out;
   logic [15:0]       drop_count_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic manual_ready = 1'b0;
   logic model_en     = 1'b0;
   logic model_ready  = 1'b1;
   int   model_cnt    = 0;

   logic mon_en       = 1'b0;
   logic prev_valid   = 1'b0;
   logic consec_seen  = 1'b0;
   int   cyc          = 0;
   int   pulse_num    = 0;
   int   pulse_cyc [8];

   assign painter_ready_in = model_en ? model_ready : manual_ready;

   always #5 clk_in = ~clk_in;

   paint_scheduler #(
      .NUM_REQ    (4),
      .FIFO_DEPTH (4),
      .MAX_RADIUS (64)
   ) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .req_valid_in       (req_valid_in),
      .req_hcount_in      (req_hcount_in),
      .req_vcount_in      (req_vcount_in),
      .req_radius_in      (req_radius_in),
      .req_ready_out      (req_ready_out),
      .painter_ready_in   (painter_ready_in),
      .painter_valid_out  (painter_valid_out),
      .painter_hcount_out (painter_hcount_out),
      .painter_vcount_out (painter_vcount_out),
      .painter_radius_out (painter_radius_out),
      .busy_out           (busy_out),
      .issued_count_out   (issued_count_out),
      .drop_count_out     (drop_count_out)
   );

   // Painter model: drops ready the cycle after a pulse, busy for 50 cycles.
   always @(posedge clk_in) begin
      if (model_en) begin
         if (model_cnt > 0) begin
            if (model_cnt == 1) model_ready <= 1'b1;
            model_cnt <= model_cnt - 1;
         end else if (painter_valid_out) begin
            model_ready <= 1'b0;
            model_cnt   <= 50;
         end
      end
   end

   always @(negedge clk_in) begin
      cyc = cyc + 1;
      if (painter_valid_out) begin
         $display("issue   t=%0t h=%0d v=%0d r=%0d issued=%0d", $time,
                  painter_hcount_out, painter_vcount_out, painter_radius_out, issued_count_out);
         if (mon_en) begin
            if (prev_valid) consec_seen = 1'b1;
            if (pulse_num < 8) pulse_cyc[pulse_num] = cyc;
            pulse_num = pulse_num + 1;
         end
      end
      prev_valid = painter_valid_out;
   end

   task automatic tick;
      @(posedge clk_in);
      #2;
   endtask

   task automatic test_reset;
      #3;
      total_cnt++; if (painter_valid_out !== 1'b0) $display("FAIL rst_valid got %0h want 0", painter_valid_out); else pass_cnt++;
      total_cnt++; if (painter_hcount_out !== 11'd0) $display("FAIL rst_hcount got %0h want 0", painter_hcount_out); else pass_cnt++;
      total_cnt++; if (issued_count_out !== 16'd0) $display("FAIL rst_issued got %0h want 0", issued_count_out); else pass_cnt++;
      total_cnt++; if (drop_count_out !== 16'd0) $display("FAIL rst_drop got %0h want 0", drop_count_out); else pass_cnt++;
      total_cnt++; if (busy_out !== 1'b0) $display("FAIL rst_busy got %0h want 0", busy_out); else pass_cnt++;
      req_valid_in = 4'b0010;
      #1;
      total_cnt++; if (req_ready_out !== 4'b0010) $display("FAIL rst_ready_comb got %b want 0010", req_ready_out); else pass_cnt++;
      req_valid_in = 4'b0000;
      tick; tick;
      rst_n_in = 1'b1;
      tick;
   endtask

   task automatic test_round_robin;
      manual_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_hcount_in[i] = 11'(10 + i);
         req_vcount_in[i] = 10'(20 + i);
         req_radius_in[i] = 17'(i + 1);
      end
      req_valid_in = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++;
         if (req_ready_out !== 4'(1 << i)) $display("FAIL rr_grant%0d got %b want %b", i, req_ready_out, 4'(1 << i)); else pass_cnt++;
         tick;
      end
      #1;
      total_cnt++; if (req_ready_out !== 4'b0000) $display("FAIL rr_full_ready got %b want 0000", req_ready_out); else pass_cnt++;
      total_cnt++; if (busy_out !== 1'b1) $display("FAIL rr_busy got %0h want 1", busy_out); else pass_cnt++;
      total_cnt++; if (painter_valid_out !== 1'b0) $display("FAIL rr_no_issue got %0h want 0", painter_valid_out); else pass_cnt++;
   endtask

   task automatic test_full_pop;
      manual_ready = 1'b1;
      #1;
      total_cnt++; if (req_ready_out !== 4'b0000) $display("FAIL fp_ready_prepop got %b want 0000", req_ready_out); else pass_cnt++;
      tick;
      total_cnt++; if (painter_valid_out !== 1'b1) $display("FAIL fp_pulse got %0h want 1", painter_valid_out); else pass_cnt++;
      total_cnt++; if (painter_hcount_out !== 11'd10) $display("FAIL fp_hcount got %0d want 10", painter_hcount_out); else pass_cnt++;
      total_cnt++; if (painter_radius_out !== 17'd1) $display("FAIL fp_radius got %0d want 1", painter_radius_out); else pass_cnt++;
      total_cnt++; if (req_ready_out !== 4'b0001) $display("FAIL fp_ready_after_pop got %b want 0001", req_ready_out); else pass_cnt++;
      manual_ready = 1'b0;
      tick;
      total_cnt++; if (req_ready_out !== 4'b0000) $display("FAIL fp_refull got %b want 0000", req_ready_out); else pass_cnt++;
      total_cnt++; if (painter_valid_out !== 1'b0) $display("FAIL fp_single_pulse got %0h want 0", painter_valid_out); else pass_cnt++;
      req_valid_in = 4'b0000;
      manual_ready = 1'b1;
      tick; tick;
      total_cnt++; if (painter_hcount_out !== 11'd11 || painter_valid_out !== 1'b1) $display("FAIL fp_issue2 got h=%0d v=%0h want h=11 v=1", painter_hcount_out, painter_valid_out); else pass_cnt++;
      manual_ready = 1'b0;
      tick;
      manual_ready = 1'b1;
      tick; tick;
      total_cnt++; if (painter_hcount_out !== 11'd12 || painter_valid_out !== 1'b1) $display("FAIL fp_issue3 got h=%0d v=%0h want h=12 v=1", painter_hcount_out, painter_valid_out); else pass_cnt++;
      manual_ready = 1'b0;
      tick;
      total_cnt++; if (issued_count_out !== 16'd3) $display("FAIL fp_issued got %0d want 3", issued_count_out); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      #1;
      rst_n_in = 1'b0;
      #1;
      total_cnt++; if (painter_valid_out !== 1'b0) $display("FAIL rm_valid got %0h want 0", painter_valid_out); else pass_cnt++;
      total_cnt++; if (painter_hcount_out !== 11'd0 || painter_vcount_out !== 10'd0 || painter_radius_out !== 17'd0)
         $display("FAIL rm_coords got %0d,%0d,%0d want 0,0,0", painter_hcount_out, painter_vcount_out, painter_radius_out); else pass_cnt++;
      total_cnt++; if (issued_count_out !== 16'd0) $display("FAIL rm_issued got %0d want 0", issued_count_out); else pass_cnt++;
      total_cnt++; if (busy_out !== 1'b0) $display("FAIL rm_busy got %0h want 0", busy_out); else pass_cnt++;
      manual_ready = 1'b1;
      tick; tick;
      rst_n_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         total_cnt++; if (painter_valid_out !== 1'b0 || busy_out !== 1'b0) $display("FAIL rm_stale%0d got v=%0h busy=%0h want 0,0", i, painter_valid_out, busy_out); else pass_cnt++;
      end
   endtask

   task automatic test_zero_clamp;
      manual_ready = 1'b1;
      req_hcount_in[1] = 11'd50;
      req_radius_in[1] = 17'd0;
      req_valid_in = 4'b0010;
      #1;
      total_cnt++; if (req_ready_out !== 4'b0010) $display("FAIL zc_ready0 got %b want 0010", req_ready_out); else pass_cnt++;
      tick;
      req_valid_in = 4'b0000;
      #1;
      total_cnt++; if (drop_count_out !== 16'd1) $display("FAIL zc_drop got %0d want 1", drop_count_out); else pass_cnt++;
      total_cnt++; if (busy_out !== 1'b0) $display("FAIL zc_busy got %0h want 0", busy_out); else pass_cnt++;
      tick; tick;
      total_cnt++; if (painter_valid_out !== 1'b0 || issued_count_out !== 16'd0) $display("FAIL zc_no_issue got v=%0h n=%0d want 0,0", painter_valid_out, issued_count_out); else pass_cnt++;
      req_hcount_in[3] = 11'd300;
      req_vcount_in[3] = 10'd200;
      req_radius_in[3] = 17'd200;
      req_valid_in = 4'b1000;
      #1;
      total_cnt++; if (req_ready_out !== 4'b1000) $display("FAIL zc_ready3 got %b want 1000", req_ready_out); else pass_cnt++;
      tick;
      req_valid_in = 4'b0000;
      tick;
      total_cnt++; if (painter_valid_out !== 1'b1) $display("FAIL zc_pulse got %0h want 1", painter_valid_out); else pass_cnt++;
      total_cnt++; if (painter_radius_out !== 17'd64) $display("FAIL zc_clamp got %0d want 64", painter_radius_out); else pass_cnt++;
      total_cnt++; if (painter_hcount_out !== 11'd300 || painter_vcount_out !== 10'd200) $display("FAIL zc_coords got %0d,%0d want 300,200", painter_hcount_out, painter_vcount_out); else pass_cnt++;
      total_cnt++; if (issued_count_out !== 16'd1) $display("FAIL zc_issued got %0d want 1", issued_count_out); else pass_cnt++;
      for (int i = 0; i < 6; i++) tick;
      total_cnt++; if (busy_out !== 1'b0 || issued_count_out !== 16'd1) $display("FAIL zc_timeout got busy=%0h n=%0d want 0,1", busy_out, issued_count_out); else pass_cnt++;
   endtask

   task automatic test_painter_model;
      int budget;
      model_en = 1'b1;
      mon_en   = 1'b1;
      req_valid_in = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         req_hcount_in[0] = 11'(500 + k);
         req_vcount_in[0] = 10'(100 + k);
         req_radius_in[0] = 17'd10;
         tick;
      end
      req_valid_in = 4'b0000;
      budget = 0;
      while (budget < 400 && !(pulse_num >= 3 && busy_out == 1'b0)) begin
         tick;
         budget++;
      end
      total_cnt++; if (pulse_num !== 3) $display("FAIL pm_pulses got %0d want 3", pulse_num); else pass_cnt++;
      if (pulse_num >= 3) begin
         total_cnt++; if (pulse_cyc[1] - pulse_cyc[0] < 51) $display("FAIL pm_gap1 got %0d want >=51", pulse_cyc[1] - pulse_cyc[0]); else pass_cnt++;
         total_cnt++; if (pulse_cyc[2] - pulse_cyc[1] < 51) $display("FAIL pm_gap2 got %0d want >=51", pulse_cyc[2] - pulse_cyc[1]); else pass_cnt++;
      end
      total_cnt++; if (consec_seen !== 1'b0) $display("FAIL pm_consecutive got %0h want 0", consec_seen); else pass_cnt++;
      total_cnt++; if (busy_out !== 1'b0 || painter_ready_in !== 1'b1) $display("FAIL pm_idle got busy=%0h rdy=%0h want 0,1", busy_out, painter_ready_in); else pass_cnt++;
      total_cnt++; if (issued_count_out !== 16'd4) $display("FAIL pm_issued got %0d want 4", issued_count_out); else pass_cnt++;
      total_cnt++; if (painter_hcount_out !== 11'd502) $display("FAIL pm_last_h got %0d want 502", painter_hcount_out); else pass_cnt++;
      mon_en   = 1'b0;
      model_en = 1'b0;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_full_pop;
      test_reset_mid;
      test_zero_clamp;
      test_painter_model;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/paint_scheduler.md
# paint_scheduler

Shares the single circle `painter` among several circle-request sources, such as the particle and cursor generators. Requests pass through a round-robin arbiter into a small FIFO. An issue state machine then feeds the painter one circle at a time, following its `ready_out` protocol. The block sits directly upstream of the painter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2–8).
- `FIFO_DEPTH`, 4: queued circles; power of two, at least 2.
- `MAX_RADIUS`, 64: larger radii are clamped to this value.

Ports:
- `clk_in` input 1: single clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `req_valid_in` input [NUM_REQ]: request per source.
- `req_hcount_in` input [NUM_REQ][11]: circle centre x.
- `req_vcount_in` input [NUM_REQ][10]: circle centre y.
- `req_radius_in` input [NUM_REQ][17]: radius.
- `req_ready_out` output [NUM_REQ]: one-hot accept, combinational.
- `painter_ready_in` input 1: the painter's `ready_out`.
- `painter_valid_out` output 1: the painter's `data_valid_in`; single-cycle pulse, registered.
- `painter_hcount_out` output 11, `painter_vcount_out` output 10, `painter_radius_out` output 17: circle for the painter; registered, held until the next issue.
- `busy_out` output 1: FIFO non-empty or FSM not in IDLE.
- `issued_count_out` output 16: circles issued; wraps.
- `drop_count_out` output 16: zero-radius requests discarded; wraps.

## Operation
- **Arbiter:**
  - Grant goes to the first valid requester at or after pointer `rr_ptr`, searching upward modulo `NUM_REQ`.
  - `req_ready_out[g]` = grant g AND FIFO not full. It depends on `req_valid_in`, the pointer and the FIFO level only.
  - On accept (valid & ready), `rr_ptr` becomes g+1 mod `NUM_REQ`. With no accept, `rr_ptr` holds.
- **Radius rules:**
  - Radius 0: accepted, not queued, `drop_count_out` +1.
  - Radius > `MAX_RADIUS`: queued as `MAX_RADIUS`.
  - Coordinates pass unmodified.
- **FIFO:**
  - Circular buffer with read/write pointers and a count.
  - The full flag gating ready is the pre-pop value. A same-cycle push and pop is legal when not full; count is unchanged.
- **Issue FSM:**
  - **IDLE:** if FIFO not empty and `painter_ready_in`, then pop, load the painter outputs, pulse `painter_valid_out` and go to WAIT_ACCEPT.
  - **WAIT_ACCEPT:** when `painter_ready_in`=0, go to WAIT_DONE. If it stays 1 for 4 cycles, go to IDLE without re-issuing; the circle counts as issued.
  - **WAIT_DONE:** when `painter_ready_in`=1, go to IDLE.
  - `issued_count_out` increments on each `painter_valid_out` pulse.
  - `painter_valid_out` is never high on two consecutive cycles.
- **Reset (asynchronous, any time, including mid-paint):**
  - State goes to IDLE.
  - FIFO empties and `rr_ptr`=0.
  - All outputs go to 0: `painter_valid_out`=0, painter coordinates 0, both counters 0, `busy_out`=0.
  - Queued circles are lost.
  - `req_ready_out` follows its combinational rule (empty FIFO), so it may be high during reset if a requester is valid.

## Timing
- Accept at edge k makes the FIFO non-empty after k. If the painter is ready, `painter_valid_out` rises after edge k+1: 2-edge latency with an empty queue.
- The painter drops ready one cycle after the pulse. The FSM therefore sees ready=0 the cycle after `painter_valid_out`.
- Back-to-back circles: the next pulse comes no earlier than 1 cycle after `painter_ready_in` returns high.
- Sustained input rate: 1 accept per cycle until full. After that, 1 accept per pop.

## Structure
- Shared package `paint_pkg` holds:
  - `typedef struct packed {hcount[10:0]; vcount[9:0]; radius[16:0];} circle_t`
  - FSM enum `sched_state_t`
  - `HCOUNT_W` / `VCOUNT_W` / `RADIUS_W` constants.
- Sub-module `circle_fifo`: parameterized by depth, carries `circle_t`, with push/pop/full/empty/count.
- The arbiter and FSM live in `paint_scheduler`.

## Test plan
- **Single request:** requester 2 sends (100, 80, r=5) with the painter ready. Expect `req_ready_out`=4'b0100 for one cycle, then `painter_valid_out` 2 edges later with outputs (100, 80, 5) and `issued_count_out`=1.
- **Round-robin:** all 4 valid continuously with the painter stalled (ready=0). Accept order is 0, 1, 2, 3. FIFO is full after 4 accepts; ready is all-zero until a pop, then grant goes to 0.
- **Zero/clamp:** r=0 gives `drop_count_out`=1 and nothing issued. r=200 is issued as 64.
- **Painter handshake model:** a painter that drops ready one cycle after the pulse and stays busy 50 cycles, with 3 queued circles. Expect 3 pulses at least 51 cycles apart, never on consecutive cycles, and `busy_out` falling after the last ready return.
- **Full with simultaneous pop:** FIFO full, painter ready, requester valid in the same cycle. Expect pop and no push (ready 0), count 3, then accept the next cycle.
- **Reset mid-operation:** assert `rst_n_in` low in WAIT_DONE with 2 queued. Expect all outputs 0 immediately (async), FIFO empty after release, and no stale issue.
